// File: rtl/qos_limiter.sv
// QoS limiter: spaces fast-bus sound/video RAM writes while the I/O bus is busy,
// so that I/O-bus DMA keeps its bandwidth. Single clock domain (CLK_FSB).
module qos_limiter #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned HOLD   = 3,
    parameter int unsigned CW     = 4
) (
    input  logic CLK_FSB,
    input  logic RES,
    input  logic TICK,
    input  logic EN,
    input  logic BACT,
    input  logic SndRAMCSWR,
    input  logic IOACT,
    output logic QoSReady,
    output logic QoSActive
);

    localparam logic [CW-1:0] WINDOW_L = CW'(WINDOW);
    localparam logic [CW-1:0] HOLD_L   = CW'(HOLD);

    typedef enum logic [1:0] {
        READY = 2'd0,
        BUSY  = 2'd1,
        SPACE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ecnt_q, ecnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic          qos_ready_q, qos_ready_d;
    logic          qos_active_q, qos_active_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (IOACT) begin
            ecnt_d = WINDOW_L;
        end else if (TICK && (ecnt_q != '0)) begin
            ecnt_d = ecnt_q - 1'b1;
        end
        qos_active_d = EN && (ecnt_d != '0);

        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            READY: begin
                // Also catches a stalled write being released after SPACE.
                if (qos_active_q && BACT && SndRAMCSWR) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!BACT) begin
                    hcnt_d  = HOLD_L;
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (hcnt_q == '0) begin
                    state_d = READY;
                end else if (TICK) begin
                    hcnt_d = hcnt_q - 1'b1;
                end
                if (!qos_active_q || !EN) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
        if (!EN) begin
            state_d = READY;
        end

        qos_ready_d = (state_d != SPACE);
    end

    always_ff @(posedge CLK_FSB) begin
        if (RES) begin
            state_q      <= READY;
            ecnt_q       <= '0;
            hcnt_q       <= '0;
            qos_ready_q  <= 1'b1;
            qos_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ecnt_q       <= ecnt_d;
            hcnt_q       <= hcnt_d;
            qos_ready_q  <= qos_ready_d;
            qos_active_q <= qos_active_d;
        end
    end

    assign QoSReady  = qos_ready_q;
    assign QoSActive = qos_active_q;

endmodule

// File: tb/tb_qos_limiter.sv
// Scoreboard bench for qos_limiter: directed scenarios followed by random traffic,
// checked against a tick-counting reference model.
module tb_qos_limiter;

    localparam int WINDOW = 8;
    localparam int HOLD   = 3;

    logic clk = 1'b0;
    logic res, tick, en, bact, snd, ioact;
    logic qos_ready, qos_active;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic ready;
        logic active;
    } exp_t;

    exp_t sb[$];

    typedef enum {P_IDLE, P_GRANT, P_GAP} phase_t;

    // Reference model: engagement is "IOACT seen and fewer than WINDOW ticks since".
    logic   io_seen;
    int     ticks_since_io;
    phase_t phase;
    int     gap_ticks;
    logic   m_active;

    qos_limiter #(
        .WINDOW(WINDOW),
        .HOLD  (HOLD),
        .CW    (4)
    ) dut (
        .CLK_FSB   (clk),
        .RES       (res),
        .TICK      (tick),
        .EN        (en),
        .BACT      (bact),
        .SndRAMCSWR(snd),
        .IOACT     (ioact),
        .QoSReady  (qos_ready),
        .QoSActive (qos_active)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic io,
                        input logic t, input logic b, input logic s);
        logic   prev_active;
        phase_t next_phase;
        exp_t   x;
        res = r; en = e; ioact = io; tick = t; bact = b; snd = s;
        @(posedge clk);
        prev_active = m_active;
        if (r) begin
            io_seen        = 1'b0;
            ticks_since_io = 0;
            phase          = P_IDLE;
            gap_ticks      = 0;
            m_active       = 1'b0;
        end else begin
            if (io) begin
                io_seen        = 1'b1;
                ticks_since_io = 0;
            end else if (t && ticks_since_io < WINDOW) begin
                ticks_since_io++;
            end
            m_active = e && io_seen && (ticks_since_io < WINDOW);

            next_phase = phase;
            case (phase)
                P_IDLE:  if (prev_active && b && s) next_phase = P_GRANT;
                P_GRANT: if (!b) begin
                    next_phase = P_GAP;
                    gap_ticks  = 0;
                end
                P_GAP: begin
                    if (gap_ticks >= HOLD) next_phase = P_IDLE;
                    else if (t) gap_ticks++;
                    if (!prev_active || !e) next_phase = P_IDLE;
                end
                default: next_phase = P_IDLE;
            endcase
            if (!e) next_phase = P_IDLE;
            phase = next_phase;
        end
        x.ready  = (phase != P_GAP);
        x.active = m_active;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (qos_ready === e.ready) n_pass++;
                else $display("FAIL qos_ready t=%0t got=%b exp=%b", $time, qos_ready, e.ready);
                n_checks++;
                if (qos_active === e.active) n_pass++;
                else $display("FAIL qos_active t=%0t got=%b exp=%b", $time, qos_active, e.active);
            end
        end
    end

    initial begin
        io_seen = 1'b0; ticks_since_io = 0; phase = P_IDLE; gap_ticks = 0; m_active = 1'b0;
        res = 1'b1; en = 1'b1; ioact = 1'b1; tick = 1'b1; bact = 1'b1; snd = 1'b1;

        // Reset with all inputs high, then release with IOACT/EN high.
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1, 1);
        step(0, 1, 1, 0, 0, 0);

        // Decay: eight ticks 16 cycles apart.
        for (int i = 0; i < 8 * 16 + 4; i++)
            step(0, 1, 0, (i % 16) == 15, 0, 0);
        // Tick coincident with IOACT reloads to full window.
        step(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 7 * 4; i++)
            step(0, 1, 0, (i % 4) == 3, 0, 0);

        // Spacing: 4-cycle sound write, then ticks every 4 cycles.
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1, (i % 4) == 2, 0, 0);

        // Stall release: second write held through SPACE, then its own spacing.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, (i % 4) == 1, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1, (i % 4) == 1, 0, 0);

        // Drop EN in SPACE; then back-to-back writes with EN=0.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, (i % 3) == 0, (i % 3) != 2, 1);

        // Non-sound traffic while engaged.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1, 0);

        // Random traffic with ticks every 4 cycles.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 24) == 0),
                 (i % 4) == 0,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qos_limiter.md
Name: qos_limiter

Overview:
- Rate-limits fast-bus writes to sound/video RAM while the slow I/O bus is busy, so that I/O-bus DMA (video/sound fetch) keeps its bandwidth.
- Produces the QoSReady term that the FSB ready logic combines as (!SndRAMCSWR || QoSReady).
- Runs in the CLK_FSB domain.
- Timing is based on a TICK strobe derived from C16M.

Parameters:
- WINDOW, 8: TICK periods of I/O-bus inactivity before QoS disengages.
- HOLD, 3: minimum TICK periods between granted sound-RAM writes while QoS is engaged.
- CW, 4: width of both internal counters; WINDOW and HOLD must each be ≤ 2^CW−1.

Ports:
- CLK_FSB, input, 1: fast-bus clock; all logic is on its rising edge.
- RES, input, 1: synchronous reset, active-high.
- TICK, input, 1: timebase strobe, high for exactly one CLK_FSB cycle per period.
- EN, input, 1: QoS enable, from the configuration switch.
- BACT, input, 1: fast-bus cycle active.
- SndRAMCSWR, input, 1: current cycle is a write to sound/video RAM.
- IOACT, input, 1: I/O bus master is running a cycle.
- QoSReady, output, 1: registered; 1 means a sound-RAM write may complete.
- QoSActive, output, 1: registered; 1 means QoS is engaged.

Behaviour:
- Reset (RES=1 at a clock edge) forces: state=READY, ecnt=0, hcnt=0, QoSReady=1, QoSActive=0. Reset mid-operation aborts any spacing interval immediately.
- Engage counter ecnt (CW bits):
  - IOACT=1: load WINDOW.
  - Otherwise, TICK=1 and ecnt≠0: decrement.
  - IOACT and TICK in the same cycle: the load wins.
  - ecnt never wraps below 0.
- QoSActive is registered as EN && (next ecnt ≠ 0), so it lags IOACT by one cycle.
- State machine (registered, one-cycle output latency):
  - READY: QoSReady=1.
    - If QoSActive && BACT && SndRAMCSWR, go to BUSY. This detects a granted write, including one that was stalled and is now released.
  - BUSY: QoSReady=1, so the granted cycle is never stalled.
    - When BACT=0, load hcnt=HOLD and go to SPACE.
  - SPACE: QoSReady=0.
    - If hcnt=0, go to READY.
    - Else if TICK=1, decrement hcnt.
    - If QoSActive=0 or EN=0, go to READY immediately; disengage overrides the remaining spacing.
- EN=0: from any state, go to READY next cycle and hold QoSReady=1.
- HOLD=0: SPACE lasts exactly one cycle (QoSReady low for one cycle).
- A sound-RAM write arriving in SPACE stalls, because the FSB sees no ready. On return to READY, QoSReady rises and that write completes and is tracked as a new grant (READY→BUSY).
- Non-sound cycles (SndRAMCSWR=0) never change state, and QoSReady has no effect on them.
- Timing of QoSReady=1 after SPACE entry: between HOLD and HOLD+1 TICK periods (TICK phase is arbitrary) plus one cycle.
- QoS not engaged (QoSActive=0): the state machine never leaves READY; QoSReady is constantly 1.

Test Plan:
- Reset: assert RES for 2 cycles with all inputs high → QoSReady=1, QoSActive=0; one cycle after release, QoSActive=1 (IOACT=1, EN=1).
- Engage/decay: pulse IOACT for 1 cycle, then 8 TICKs spaced 16 cycles apart → QoSActive=1 until the cycle after the 8th TICK, then 0. A TICK coincident with an IOACT pulse → ecnt reloads to 8, not 7.
- Spacing (HOLD=3, engaged): sound write with BACT high for 4 cycles → QoSReady stays 1 throughout; QoSReady=0 from the cycle after BACT falls until the cycle after hcnt reaches 0 (3 TICKs).
- Stall release: second sound write starts during SPACE → QoSReady low while BACT is held; after the 3rd TICK, QoSReady=1, state BUSY, and a new spacing interval follows that write's BACT deassert.
- Disengage/disable: in SPACE, drop EN (or let ecnt expire) → QoSReady=1 on the next cycle. With EN=0, back-to-back sound writes never see QoSReady=0.
- Non-sound traffic: engaged, 10 back-to-back cycles with SndRAMCSWR=0 → state stays READY, QoSReady constantly 1.
